// File: rtl/sipo_ctrl_pkg.sv
// Shared types and helpers for the SIPO frame controller.
package sipo_ctrl_pkg;

    // IDLE: no partial word held; SHIFT: 0 < bit count < N
    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    // Bit-counter width; clamped to 1 so degenerate widths still elaborate
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_shift_stage.sv
// N-bit MSB-first shift register with enable and synchronous active-low clear.
module sipo_shift_stage
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         en_i,
    input  logic         si_i,
    output logic [N-1:0] sr_o
);

    logic [N-1:0] sr_q, sr_d;

    // Next shift value: shift in at the LSB so the first bit ends up at the MSB
    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            sr_d = {sr_q[N-2:0], si_i};
        end
    end

    // Shift register state
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;

endmodule

// File: rtl/sipo_frame_controller.sv
// Serial-in/parallel-out frame controller: bit counting, frame resync,
// one-deep output buffer with valid/ready, sticky overflow and abort pulse.
module sipo_frame_controller
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         si,
    input  logic         si_valid,
    input  logic         sof,
    output logic [N-1:0] po_data,
    output logic         po_valid,
    input  logic         po_ready,
    output logic         busy,
    output logic         overflow,
    output logic         sync_err,
    input  logic         clear_ovf
);

    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     po_data_q, po_data_d;
    logic             po_valid_q, po_valid_d;
    logic             overflow_q, overflow_d;
    logic             sync_err_q, sync_err_d;

    logic [N-1:0]     sr;
    logic [N-1:0]     word;
    logic             complete;
    // The oldest bit is shifted out when a word completes and is never read
    logic             unused_sr_msb;

    sipo_shift_stage #(
        .N (N)
    ) u_shift (
        .clk_i  (clk),
        .clr_ni (reset),
        .en_i   (si_valid),
        .si_i   (si),
        .sr_o   (sr)
    );

    assign unused_sr_msb = sr[N-1];
    // Completed word includes the bit being accepted this cycle
    assign word = {sr[N-2:0], si};

    // Next-state: FSM/counter, buffer load/drain, overflow and resync flags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        po_data_d  = po_data_q;
        po_valid_d = po_valid_q;
        overflow_d = overflow_q;
        sync_err_d = 1'b0;
        complete   = 1'b0;

        if (po_valid_q && po_ready) begin
            po_valid_d = 1'b0;
        end
        if (clear_ovf) begin
            overflow_d = 1'b0;
        end

        if (si_valid) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StShift;
                    cnt_d   = CNT_W'(1);
                end
                StShift: begin
                    if (sof) begin
                        // Partial word abandoned; this bit restarts the word
                        sync_err_d = 1'b1;
                        cnt_d      = CNT_W'(1);
                    end else if (cnt_q == CntLast) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        // Load wins over drain; a set overflow wins over clear_ovf
        if (complete) begin
            if (!po_valid_q || po_ready) begin
                po_data_d  = word;
                po_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // FSM, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            po_data_q  <= '0;
            po_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            po_data_q  <= po_data_d;
            po_valid_q <= po_valid_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign po_data  = po_data_q;
    assign po_valid = po_valid_q;
    assign overflow = overflow_q;
    assign sync_err = sync_err_q;
    assign busy     = (state_q == StShift);

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Randomised + directed bench for sipo_frame_controller with a queue-based model.
module tb_sipo_frame_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         si = 1'b0;
    logic         si_valid = 1'b0;
    logic         sof = 1'b0;
    logic [N-1:0] po_data;
    logic         po_valid;
    logic         po_ready = 1'b0;
    logic         busy;
    logic         overflow;
    logic         sync_err;
    logic         clear_ovf = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sipo_frame_controller #(
        .N (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .si        (si),
        .si_valid  (si_valid),
        .sof       (sof),
        .po_data   (po_data),
        .po_valid  (po_valid),
        .po_ready  (po_ready),
        .busy      (busy),
        .overflow  (overflow),
        .sync_err  (sync_err),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit           partial[$];
    logic [N-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_ovf = 1'b0;
    bit           m_sync = 1'b0;

    always @(posedge clk) begin
        bit           done;
        bit           drain;
        logic [N-1:0] w;
        done = 1'b0;
        w = '0;
        if (!reset) begin
            partial.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_sync  = 1'b0;
        end else begin
            m_sync = 1'b0;
            drain = m_valid && po_ready;
            if (si_valid) begin
                if (sof && partial.size() > 0) begin
                    m_sync = 1'b1;
                    partial.delete();
                end
                partial.push_back(si);
                if (partial.size() == N) begin
                    for (int i = 0; i < N; i++) w = {w[N-2:0], partial[i]};
                    partial.delete();
                    done = 1'b1;
                end
            end
            if (clear_ovf) m_ovf = 1'b0;
            if (done && (!m_valid || po_ready)) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                if (done) m_ovf = 1'b1;
                if (drain) m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("po_data",  32'(po_data),  32'(m_data));
            check("po_valid", 32'(po_valid), 32'(m_valid));
            check("busy",     32'(busy),     32'(partial.size() > 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("sync_err", 32'(sync_err), 32'(m_sync));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input bit b, input bit s);
        si = b; si_valid = 1'b1; sof = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0; sof = 1'b0; si = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit gaps);
        for (int i = N - 1; i >= 0; i--) begin
            send_bit(w[i], 1'b0);
            if (gaps && i != 0) idle(1);
        end
    endtask

    initial begin
        logic [N-1:0] v;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        check("reset_po_valid", 32'(po_valid), 32'd0);
        check("reset_po_data",  32'(po_data),  32'd0);

        // Back-to-back bits 1,0,1,1,0,0,1,0 -> 8'hB2
        po_ready = 1'b1;
        v = 8'hB2;
        for (int i = N - 1; i >= 0; i--) begin
            send_bit(v[i], 1'b0);
            if (i != 0) check("busy_mid_word", 32'(busy), 32'd1);
        end
        idle(0);
        check("b2_valid", 32'(po_valid), 32'd1);
        check("b2_data",  32'(po_data),  32'hB2);
        check("b2_model", 32'(m_data),   32'hB2);
        @(negedge clk);
        check("b2_valid_one_cycle", 32'(po_valid), 32'd0);

        // Same word with si_valid toggling
        send_word(8'hB2, 1'b1);
        idle(0);
        check("gap_valid", 32'(po_valid), 32'd1);
        check("gap_data",  32'(po_data),  32'hB2);
        idle(2);

        // Backpressure overflow
        po_ready = 1'b0;
        send_word(8'hA5, 1'b0);
        send_word(8'h3C, 1'b0);
        idle(0);
        check("ovf_data",  32'(po_data),  32'hA5);
        check("ovf_valid", 32'(po_valid), 32'd1);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_model", 32'(m_ovf),    32'd1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        po_ready = 1'b1;
        idle(2);

        // Resync: 3 bits then sof, then 7 more ones -> 8'hFF
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("sync_pulse", 32'(sync_err), 32'd1);
        send_bit(1'b1, 1'b0);
        check("sync_single", 32'(sync_err), 32'd0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        idle(0);
        check("sync_data", 32'(po_data), 32'hFF);
        idle(2);

        // Simultaneous drain and load
        po_ready = 1'b0;
        send_word(8'h11, 1'b0);
        v = 8'h22;
        for (int i = N - 1; i >= 1; i--) send_bit(v[i], 1'b0);
        check("hold_data", 32'(po_data), 32'h11);
        po_ready = 1'b1;
        send_bit(v[0], 1'b0);
        idle(0);
        check("swap_data",  32'(po_data),  32'h22);
        check("swap_valid", 32'(po_valid), 32'd1);
        check("swap_ovf",   32'(overflow), 32'd0);
        idle(2);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        idle(0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_data",  32'(po_data),  32'd0);
        check("rst_valid", 32'(po_valid), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        reset = 1'b1;
        send_word(8'h81, 1'b0);
        idle(0);
        check("post_rst_data", 32'(po_data), 32'h81);
        idle(2);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            si        = 1'($urandom_range(0, 1));
            si_valid  = ($urandom_range(0, 99) < 70);
            sof       = ($urandom_range(0, 99) < 8);
            po_ready  = ($urandom_range(0, 99) < 55);
            clear_ovf = ($urandom_range(0, 99) < 5);
            reset     = ($urandom_range(0, 999) >= 4);
            @(negedge clk);
        end
        reset = 1'b1;
        idle(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_frame_controller.md
Name: sipo_frame_controller

Overview:
Sequences a serial-in/parallel-out deserializer for framed serial links. Gates the shift on a per-bit valid strobe, counts bits to N, and captures each completed word into a one-deep output buffer with a valid/ready handshake. Handles frame resync, backpressure overflow and partial-frame abort. Sits between a serial pin/CDC stage and a word-wide consumer (FIFO or register file).

Parameters:
N, 8, word width in bits; legal range N >= 2
CNT_W, $clog2(N), bit-counter width (localparam, derived, not overridable)

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-low reset; sampled on rising clk edge
si  input  1  serial data bit
si_valid  input  1  si carries a valid bit this cycle
sof  input  1  start-of-frame; qualified by si_valid; marks si as bit 0 of a new word
po_data  output  N  captured parallel word, MSB = first bit received
po_valid  output  1  po_data holds an unconsumed word
po_ready  input  1  consumer accepts po_data when po_valid && po_ready
busy  output  1  partial word in progress (state SHIFT)
overflow  output  1  sticky: completed word dropped because buffer full
sync_err  output  1  one-cycle pulse: sof arrived while a partial word was in progress
clear_ovf  input  1  clears overflow

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, bit count=0, shift reg=0, po_data=0, po_valid=0, busy=0, overflow=0, sync_err=0. Reset mid-frame discards partial and buffered words.
- Shift is MSB-first: on an accepted bit, sr <= {sr[N-2:0], si}; count increments. No shift/count change when si_valid==0.
- FSM states: IDLE (count==0, busy=0), SHIFT (0<count<N, busy=1).
  - IDLE: si_valid -> accept bit as bit 0, count=1, go SHIFT (sof optional in IDLE).
  - SHIFT, si_valid && !sof && count<N-1: accept, count++.
  - SHIFT, si_valid && !sof && count==N-1: word complete = {sr[N-2:0], si}; count=0, go IDLE.
  - SHIFT, si_valid && sof: discard partial, sync_err=1 for one cycle, accept si as bit 0, count=1, stay SHIFT.
- Capture: completed word written to po_data on the same edge that accepts the last bit; po_valid rises the cycle after the last bit (latency 1 cycle).
- Buffer rules: load allowed if po_valid==0 or (po_valid && po_ready) in that cycle (simultaneous drain+load: new word loaded, po_valid stays 1). Otherwise word dropped, po_data/po_valid unchanged, overflow set.
- po_valid falls the cycle after po_valid && po_ready with no simultaneous load. po_data stable while po_valid && !po_ready.
- overflow: sticky until clear_ovf; if set and clear occur same cycle, set wins.
- sync_err: registered, high exactly one cycle per aborted partial; never asserted from IDLE.
- Counter wraps only via completion; never exceeds N-1.

Decomposition:
- Package sipo_ctrl_pkg: state enum typedef (IDLE, SHIFT), helper function for counter width.
- One sub-module: sipo_shift_stage (N-bit shift register with enable and synchronous active-low clear); controller holds FSM, counter, output buffer, flags.

Test Plan:
- Reset, then N=8 bits 1,0,1,1,0,0,1,0 on consecutive cycles with po_ready=1 -> po_data=8'hB2, po_valid high for exactly one cycle, 1 cycle after last bit; busy high during bits 1..7 window.
- Same word with si_valid toggling 0/1 every cycle -> po_data=8'hB2, capture 1 cycle after 8th valid bit; no shift on invalid cycles.
- po_ready=0, send 8'hA5 then 8'h3C -> po_data stays 8'hA5, po_valid=1, overflow=1; pulse clear_ovf -> overflow=0.
- Send 3 bits, then sof with si_valid followed by 7 more bits of 8'hFF -> sync_err single-cycle pulse, po_data=8'hFF.
- po_valid=1 holding 8'h11, po_ready=1 in the same cycle 8'h22 completes -> po_data=8'h22, po_valid stays 1, overflow=0.
- reset=0 asserted after 5 bits -> all outputs 0; next full 8 bits 8'h81 yield po_data=8'h81.
